im_port_arbiter: RTL
====================

// Module: im_port_arbiter
// PURPOSE
// Shares the single-port, synchronous-read instruction memory array between two requesters:
//   - the IF-stage fetch port (read only);
//   - the loader/debug port (read/write), used to load code at boot and to patch it at run time.
// Sits between the IF stage and the IM array. Handles arbitration, the one-cycle read-return
// pipeline, boot sequencing, fetch flush and alignment checking.
// PARAMETERS
// AW         10  word-address width of the IM array (1024 words; byte address bits [AW+1:2])
// STARVE_MAX 4   maximum consecutive loader grants in RUN before fetch must win one cycle
// BASE_ADDR  32'h0000_3000  byte address of IM word 0; subtracted before indexing
// PORTS
// clk        in  1   rising-edge clock
// reset_n    in  1   asynchronous, active-low reset
// boot_done  in  1   one-cycle pulse: loading finished, enter RUN
// f_req      in  1   fetch read request
// f_addr     in  32  fetch byte address (the PC)
// f_flush    in  1   discard any fetch response due next cycle (branch redirect)
// f_gnt      out 1   fetch request accepted this cycle
// f_rvalid   out 1   fetch data valid (one cycle after f_gnt)
// f_rdata    out 32  fetch instruction word
// f_err      out 1   with f_rvalid: address misaligned or out of range; f_rdata = 0
// l_req      in  1   loader request
// l_we       in  1   loader write (1) or read (0)
// l_addr     in  32  loader byte address
// l_wdata    in  32  loader write data
// l_gnt      out 1   loader request accepted this cycle
// l_rvalid   out 1   loader read data valid (one cycle after a read l_gnt)
// l_rdata    out 32  loader read data
// mem_en     out 1   IM array enable
// mem_we     out 1   IM array write enable
// mem_addr   out AW  IM array word address
// mem_wdata  out 32  IM array write data
// mem_rdata  in  32  IM array read data, valid the cycle after mem_en && !mem_we
// BEHAVIOUR
// - Reset: state=BOOT, starve_cnt=0, resp_owner=NONE. All outputs 0.
// - Offset address = addr - BASE_ADDR; word index = offset[AW+1:2].
//   Bad address: offset[1:0]!=0 or offset >= 4<<AW.
// - State BOOT:
//   - Only the loader is served; f_gnt=0.
//   - boot_done -> RUN on the next edge. Loader requests granted in the same cycle still complete.
// - State RUN: at most one grant per cycle; gnt is combinational from the current-cycle req.
//   - Fetch wins when f_req && (!l_req || starve_cnt==STARVE_MAX); otherwise loader wins.
//   - starve_cnt: +1 per cycle where the loader is granted while f_req=1; cleared on a fetch grant
//     or when f_req=0; saturates at STARVE_MAX.
// - Grant with good address:
//   - mem_en=1, mem_addr=index, mem_we=l_we (loader) or 0 (fetch), mem_wdata=l_wdata.
// - Grant with bad address: mem_en=0, mem_we=0. No array access; a write is dropped.
// - Response pipeline: the cycle after a granted read (including a bad-address fetch):
//   - fetch: f_rvalid=1, f_rdata=mem_rdata (or 0 with f_err=1 if the address was bad);
//   - loader read: l_rvalid=1, l_rdata=mem_rdata (0 if bad address).
//   - Loader writes produce no rvalid.
// - Reads and writes may issue back-to-back; there is no bubble.
//   Read-after-write to the same word returns the new data, because the array is write-first.
// - f_flush:
//   - in the cycle a fetch is granted, suppresses that grant's response next cycle (f_rvalid=0);
//   - in the response cycle itself, forces f_rvalid=0;
//   - does not block a new fetch grant in the same cycle.
// - Idle (no grant): mem_en=0; f_rvalid/l_rvalid=0 next cycle. rdata holds the last value.
// - Asynchronous reset mid-operation: any in-flight response is lost (no rvalid) and the state
//   returns to BOOT.
// TESTING
// - Reset, then load: loader writes 0x3000..0x300C = A,B,C,D.
//   -> 4 consecutive l_gnt, mem_addr 0..3, f_gnt=0 throughout BOOT.
// - boot_done, then fetch 0x3000, 0x3004 back-to-back.
//   -> f_rvalid on cycles +1,+2 with data A,B; f_err=0.
// - Contention: l_req and f_req held high for 10 cycles in RUN.
//   -> grant pattern L,L,L,L,F repeating; f_gnt every 5th cycle.
// - Fetch 0x3002 and fetch 0x4000 (AW=10).
//   -> mem_en=0, f_rvalid=1 with f_err=1, f_rdata=0 the next cycle.
// - Fetch grant with f_flush=1, then loader read of 0x3008 the next cycle.
//   -> no f_rvalid; l_rvalid one cycle later with l_rdata=C.
// - reset_n low during an outstanding fetch read.
//   -> f_rvalid=0; state BOOT; f_gnt=0 until the next boot_done.

Source files
------------

// File: rtl/im_port_arbiter_if.sv
// Bundles the fetch, loader and IM-array signals around im_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters/array side.
interface im_port_arbiter_if #(
  parameter int unsigned AW = 10
);
  logic          boot_done;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_flush;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  boot_done, f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output boot_done, f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Shares the single-port instruction memory between the IF fetch port and the
// loader/debug port: boot sequencing, arbitration, read-return pipeline, flush.
module im_port_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
  input logic              clk,
  input logic              reset_n,
  im_port_arbiter_if.slave bus
);
  localparam int unsigned CW       = $clog2(STARVE_MAX + 1);
  localparam logic [31:0] IM_BYTES = 32'(4) << AW;

  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_t;

  state_t        state;
  owner_t        resp_owner;
  logic          resp_bad;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   f_hold;
  logic [31:0]   l_hold;

  logic [31:0]   f_off, l_off;
  logic          f_bad, l_bad;
  logic          f_gnt_c, l_gnt_c, f_acc_c, l_acc_c;
  logic          f_rvalid_c, l_rvalid_c;
  logic [31:0]   f_data_c, l_data_c;

  // Address decode: rebase, then reject misaligned or beyond-array addresses
  assign f_off = bus.f_addr - BASE_ADDR;
  assign l_off = bus.l_addr - BASE_ADDR;
  assign f_bad = (f_off[1:0] != 2'b00) || (f_off >= IM_BYTES);
  assign l_bad = (l_off[1:0] != 2'b00) || (l_off >= IM_BYTES);

  // Fetch only competes in RUN; after STARVE_MAX loader wins it takes one cycle
  assign f_gnt_c = reset_n && (state == ST_RUN) && bus.f_req &&
                   (!bus.l_req || (starve_cnt == CW'(STARVE_MAX)));
  assign l_gnt_c = reset_n && bus.l_req && !f_gnt_c;
  assign f_acc_c = f_gnt_c && !f_bad;
  assign l_acc_c = l_gnt_c && !l_bad;

  assign bus.f_gnt     = f_gnt_c;
  assign bus.l_gnt     = l_gnt_c;
  assign bus.mem_en    = f_acc_c || l_acc_c;
  assign bus.mem_we    = l_acc_c && bus.l_we;
  assign bus.mem_addr  = f_acc_c ? f_off[AW+1:2] : (l_acc_c ? l_off[AW+1:2] : '0);
  assign bus.mem_wdata = l_acc_c ? bus.l_wdata : '0;

  // Response cycle: array data passes straight through; a flush kills it here too
  assign f_rvalid_c = (resp_owner == OWN_FETCH) && !bus.f_flush;
  assign l_rvalid_c = (resp_owner == OWN_LOAD);
  assign f_data_c   = resp_bad ? 32'h0 : bus.mem_rdata;
  assign l_data_c   = resp_bad ? 32'h0 : bus.mem_rdata;

  assign bus.f_rvalid = f_rvalid_c;
  assign bus.f_err    = f_rvalid_c && resp_bad;
  assign bus.f_rdata  = f_rvalid_c ? f_data_c : f_hold;
  assign bus.l_rvalid = l_rvalid_c;
  assign bus.l_rdata  = l_rvalid_c ? l_data_c : l_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BOOT;
      resp_owner <= OWN_NONE;
      resp_bad   <= 1'b0;
      starve_cnt <= '0;
      f_hold     <= '0;
      l_hold     <= '0;
    end else begin
      if (state == ST_BOOT && bus.boot_done) state <= ST_RUN;

      if (state != ST_RUN || !bus.f_req || f_gnt_c)
        starve_cnt <= '0;
      else if (l_gnt_c && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + CW'(1);

      // Flush in the grant cycle cancels the response before it is scheduled
      if (f_gnt_c && !bus.f_flush) begin
        resp_owner <= OWN_FETCH;
        resp_bad   <= f_bad;
      end else if (l_gnt_c && !bus.l_we) begin
        resp_owner <= OWN_LOAD;
        resp_bad   <= l_bad;
      end else begin
        resp_owner <= OWN_NONE;
        resp_bad   <= 1'b0;
      end

      if (f_rvalid_c) f_hold <= f_data_c;
      if (l_rvalid_c) l_hold <= l_data_c;
    end
  end
endmodule
